// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - issue/result handshake bundle between EX and the mul/div unit
interface ex_muldiv_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [TAG_W-1:0] tag;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport slave (
    input  in_valid, op, a, b, tag, kill, out_ready,
    output in_ready, out_valid, result, out_tag, busy
  );

  modport master (
    output in_valid, op, a, b, tag, kill, out_ready,
    input  in_ready, out_valid, result, out_tag, busy
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the execute stage
module ex_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1,
  parameter int TAG_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  ex_muldiv_unit_if.slave    io
);

  localparam int N_MUL = XLEN / MUL_BITS;
  localparam int N_DIV = XLEN;
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(N_MUL - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(N_DIV - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_div_in;
  logic              sgn_a_in, sgn_b_in;
  logic              neg_a_in, neg_b_in;
  logic [XLEN-1:0]   mag_a_in, mag_b_in;
  logic              div_zero_in, div_ovf_in;
  logic [XLEN-1:0]   special_res;

  always_comb begin
    is_div_in   = io.op[2];
    sgn_a_in    = !(io.op == OP_MULHU || io.op == OP_DIVU || io.op == OP_REMU);
    sgn_b_in    = (io.op == OP_MUL) || (io.op == OP_MULH) ||
                  (io.op == OP_DIV) || (io.op == OP_REM);
    neg_a_in    = sgn_a_in && io.a[XLEN-1];
    neg_b_in    = sgn_b_in && io.b[XLEN-1];
    mag_a_in    = neg_a_in ? -io.a : io.a;
    mag_b_in    = neg_b_in ? -io.b : io.b;
    div_zero_in = is_div_in && (io.b == '0);
    div_ovf_in  = ((io.op == OP_DIV) || (io.op == OP_REM)) &&
                  (io.a == MOST_NEG) && (io.b == '1);
    // op[1] separates REM/REMU from DIV/DIVU
    if (io.op[1]) special_res = div_zero_in ? io.a : '0;
    else          special_res = div_zero_in ? '1 : io.a;
  end

  // acc_q holds {high partial product, unconsumed multiplier} or {remainder, dividend/quotient}
  logic [XLEN+MUL_BITS-1:0] pp;
  logic [XLEN+MUL_BITS-1:0] mul_sum;
  logic [2*XLEN-1:0]        mul_step;
  logic [XLEN:0]            div_diff;
  logic [2*XLEN-1:0]        div_step;
  logic [2*XLEN-1:0]        step;
  logic [2*XLEN-1:0]        mul_full;
  logic [XLEN-1:0]          div_sel;
  logic [XLEN-1:0]          fin;
  logic [CNT_W-1:0]         last;

  always_comb begin
    pp = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (acc_q[i]) pp = pp + ({{MUL_BITS{1'b0}}, opnd_q} << i);
    end
    mul_sum  = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]} + pp;
    mul_step = {mul_sum, acc_q[XLEN-1:MUL_BITS]};

    div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    if (div_diff[XLEN]) div_step = {acc_q[2*XLEN-2:0], 1'b0};
    else                div_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    step     = op_q[2] ? div_step : mul_step;
    mul_full = neg_q ? -step : step;
    div_sel  = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    if (op_q[2])              fin = neg_q ? -div_sel : div_sel;
    else if (op_q == OP_MUL)  fin = mul_full[XLEN-1:0];
    else                      fin = mul_full[2*XLEN-1:XLEN];

    last = op_q[2] ? DIV_LAST : MUL_LAST;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tag_d    = tag_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (io.in_valid && !io.kill) begin
          op_d   = io.op;
          tag_d  = io.tag;
          cnt_d  = '0;
          neg_d  = (io.op == OP_REM) ? neg_a_in : (neg_a_in ^ neg_b_in);
          opnd_d = is_div_in ? mag_b_in : mag_a_in;
          acc_d  = {{XLEN{1'b0}}, (is_div_in ? mag_a_in : mag_b_in)};
          if (div_zero_in || div_ovf_in) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == last) begin
          result_d = fin;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (io.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // a flush beats both a pending accept and a consuming out_ready
    if (io.kill) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      tag_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign io.in_ready  = (state_q == S_IDLE);
  assign io.busy      = (state_q != S_IDLE);
  assign io.out_valid = (state_q == S_DONE);
  assign io.result    = result_q;
  assign io.out_tag   = tag_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - scoreboard bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.XLEN(32), .TAG_W(5)) if0 ();
  ex_muldiv_unit_if #(.XLEN(32), .TAG_W(5)) if1 ();

  ex_muldiv_unit #(.XLEN(32), .MUL_BITS(1), .TAG_W(5)) dut0 (.clk(clk), .rst(rst), .io(if0));
  ex_muldiv_unit #(.XLEN(32), .MUL_BITS(4), .TAG_W(5)) dut1 (.clk(clk), .rst(rst), .io(if1));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  int cyc = 0;
  int busy_tot = 0;
  int errors = 0;
  int checks = 0;
  logic        prev_v [2];
  logic [31:0] hold_r [2];
  logic [4:0]  hold_t [2];

  vec_t vecs [13] = '{
    '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33},
    '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33},
    '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33},
    '{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33},
    '{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33},
    '{DIVU,   32'd100,      32'd7,        32'd14,       33},
    '{REMU,   32'd100,      32'd7,        32'd2,        33},
    '{MUL,    32'h12345678, 32'h10,       32'h23456780, 33},
    '{MULHU,  32'h12345678, 32'h10,       32'h00000001, 33},
    '{DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1},
    '{REM,    32'd5,        32'd0,        32'd5,        1},
    '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
    '{REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1}
  };

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (if0.busy) busy_tot <= busy_tot + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic v, input logic [31:0] r, input logic [4:0] t);
    exp_t e;
    int   sz;
    sz = (id == 0) ? q0.size() : q1.size();
    if (v && !prev_v[id]) begin
      if (sz == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out dut%0d: got result %0h, expected no output", id, r);
      end else begin
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        chk($sformatf("result dut%0d", id), 64'(r), 64'(e.res));
        chk($sformatf("out_tag dut%0d", id), 64'(t), 64'(e.tag));
        chk($sformatf("latency dut%0d", id), 64'(cyc - e.acc), 64'(e.lat));
      end
      hold_r[id] = r;
      hold_t[id] = t;
    end else if (v) begin
      chk($sformatf("stable_result dut%0d", id), 64'(r), 64'(hold_r[id]));
      chk($sformatf("stable_tag dut%0d", id), 64'(t), 64'(hold_t[id]));
    end
    prev_v[id] = v;
  endtask

  always @(negedge clk) begin
    mon(0, if0.out_valid, if0.result, if0.out_tag);
    mon(1, if1.out_valid, if1.result, if1.out_tag);
  end

  task automatic drive(input int id, input logic v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    if (id == 0) begin
      if0.in_valid = v; if0.op = op; if0.a = a; if0.b = b; if0.tag = tag;
    end else begin
      if1.in_valid = v; if1.op = op; if1.a = a; if1.b = b; if1.tag = tag;
    end
  endtask

  // called at a negedge; holds in_valid until the unit is ready, then records the accept cycle
  task automatic issue(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] res, input int lat, input bit expect_out);
    int   n;
    logic rdy;
    exp_t e;
    n = 0;
    drive(id, 1'b1, op, a, b, tag);
    rdy = (id == 0) ? if0.in_ready : if1.in_ready;
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
      rdy = (id == 0) ? if0.in_ready : if1.in_ready;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: in_ready stayed 0, expected 1", id);
    end else if (expect_out) begin
      e = '{res, tag, cyc, lat};
      if (id == 0) q0.push_back(e);
      else         q1.push_back(e);
    end
    @(negedge clk);
    drive(id, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic wait_done(input int id);
    int n;
    n = 0;
    while (n < 300 && !(((id == 0) ? q0.size() : q1.size()) == 0 &&
                        ((id == 0) ? if0.in_ready : if1.in_ready))) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL done_timeout dut%0d: result not consumed, expected within 300 cycles", id);
    end
  endtask

  initial begin
    int b0;
    int n;
    prev_v[0] = 1'b0;
    prev_v[1] = 1'b0;
    drive(0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    drive(1, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    if0.kill = 1'b0; if0.out_ready = 1'b1;
    if1.kill = 1'b0; if1.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 64'(if0.in_ready), 64'd1);
    chk("reset out_valid", 64'(if0.out_valid), 64'd0);
    chk("reset busy", 64'(if0.busy), 64'd0);
    chk("reset result", 64'(if0.result), 64'd0);
    chk("reset out_tag", 64'(if0.out_tag), 64'd0);

    issue(0, MUL, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 33, 1'b1);
    issue(1, MUL, 32'd7, 32'hFFFFFFFD, 5'd2, 32'hFFFFFFEB, 9, 1'b1);
    wait_done(0);
    wait_done(1);

    for (int i = 0; i < 13; i++) begin
      b0 = busy_tot;
      issue(0, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 3), vecs[i].res, vecs[i].lat, 1'b1);
      wait_done(0);
      chk($sformatf("busy_cycles vec%0d", i), 64'(busy_tot - b0), 64'(vecs[i].lat));
    end

    // backpressure: DONE held while out_ready is low, new op waits for in_ready
    if0.out_ready = 1'b0;
    issue(0, DIVU, 32'd100, 32'd7, 5'd13, 32'd14, 33, 1'b1);
    n = 0;
    while (!if0.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp out_valid reached", 64'(if0.out_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp in_ready", 64'(if0.in_ready), 64'd0);
      chk("bp out_valid", 64'(if0.out_valid), 64'd1);
    end
    if0.out_ready = 1'b1;
    chk("consume in_ready", 64'(if0.in_ready), 64'd0);
    issue(0, MUL, 32'd3, 32'd4, 5'd7, 32'd12, 33, 1'b1);
    wait_done(0);

    // kill on the 10th CALC cycle of a divide
    issue(0, DIV, 32'd100, 32'd7, 5'd2, 32'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    chk("pre-kill busy", 64'(if0.busy), 64'd1);
    if0.kill = 1'b1;
    @(negedge clk);
    if0.kill = 1'b0;
    chk("kill in_ready", 64'(if0.in_ready), 64'd1);
    chk("kill busy", 64'(if0.busy), 64'd0);
    chk("kill out_valid", 64'(if0.out_valid), 64'd0);
    repeat (40) @(negedge clk);

    // kill and in_valid together in IDLE
    if0.kill = 1'b1;
    drive(0, 1'b1, MUL, 32'd5, 32'd5, 5'd4);
    @(negedge clk);
    if0.kill = 1'b0;
    drive(0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    chk("kill_idle busy", 64'(if0.busy), 64'd0);
    chk("kill_idle in_ready", 64'(if0.in_ready), 64'd1);
    repeat (40) @(negedge clk);

    // asynchronous reset mid-multiply
    issue(0, MUL, 32'd5, 32'd6, 5'd3, 32'd0, 0, 1'b0);
    repeat (5) @(negedge clk);
    chk("pre-rst busy", 64'(if0.busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst out_valid", 64'(if0.out_valid), 64'd0);
    chk("rst busy", 64'(if0.busy), 64'd0);
    chk("rst in_ready", 64'(if0.in_ready), 64'd1);
    chk("rst result", 64'(if0.result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(0, MULHU, 32'hFFFF0000, 32'h00010000, 5'd9, 32'h0000FFFF, 33, 1'b1);
    wait_done(0);

    chk("scoreboard0 empty", 64'(q0.size()), 64'd0);
    chk("scoreboard1 empty", 64'(q1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit that sits beside the ALU in the execute stage. It is parametrised in datapath width and in multiplier radix.
- EX hands it an operation with a valid/ready handshake.
- The result returns through a valid/ready handshake towards MEM.
- `busy` feeds the hazard unit so IF/ID/EX stall while an operation is in flight.
- `kill` aborts an in-flight operation on a branch/jump flush.

Parameters:
- XLEN, 32, operand/result width; must be even and ≥ 8.
- MUL_BITS, 1, multiplier bits retired per CALC cycle; legal values 1, 2, 4; must divide XLEN.
- TAG_W, 5, width of the destination-register tag carried alongside the operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept (state IDLE).
- op  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 operand (already forwarded).
- b  in  XLEN  rs2 operand (already forwarded).
- tag  in  TAG_W  rd address of the operation.
- kill  in  1  synchronous flush of any operation held or in flight.
- out_valid  out  1  result available.
- out_ready  in  1  downstream consumes the result.
- result  out  XLEN  operation result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  high in CALC or DONE; drives the hazard-unit stall.

Behaviour:
- States: IDLE, CALC, DONE. Reset value is IDLE; in_ready=1, out_valid=0, busy=0, result=0, out_tag=0, all internal registers 0.
- rst asserted at any time (including mid-CALC) forces the reset values immediately, without waiting for a clock edge.
- Accept: in_valid && in_ready && !kill on a clk edge. On accept, latch op, tag, operand magnitudes and result sign.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - Unsigned variants: both unsigned.
- Multiply path:
  - Shift-add over the magnitudes, MUL_BITS bits per cycle, into a 2·XLEN product.
  - Takes N_MUL = XLEN/MUL_BITS CALC cycles.
  - On leaving CALC, negate the product if the result sign is negative.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide path:
  - Restoring radix-2 divide over the magnitudes; takes N_DIV = XLEN CALC cycles.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Special cases bypass CALC (IDLE→DONE directly), with result registered on accept:
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give a.
  - Signed overflow (a = most-negative, b = −1): DIV gives a; REM gives 0.
- Latency, counted from the accepting edge:
  - Normal operation: out_valid rises N+1 cycles later (N CALC cycles, then the DONE entry edge).
  - Special case: out_valid rises 1 cycle later.
- Transitions:
  - IDLE→CALC on accept of a normal operation; IDLE→DONE on accept of a special case.
  - CALC→DONE when the iteration counter reaches N−1.
  - DONE→IDLE on out_ready.
- DONE holds out_valid=1 with result and out_tag stable until out_ready=1. Consumption happens on the edge where out_valid && out_ready.
- No back-to-back issue: in_ready is low throughout DONE, including the consuming cycle. The next accept is possible at the earliest one cycle after consumption.
- kill:
  - In any state, the next edge goes to IDLE, clears out_valid and discards the result.
  - kill has priority over accept and over out_ready.
  - kill in IDLE has no effect other than blocking the same-cycle accept.
- busy = (state != IDLE). in_ready = (state == IDLE). Both are combinational from state.
- The iteration counter is ⌈log2(XLEN)⌉+1 bits and resets to 0 on every accept.

Test Plan:
1. XLEN=32, MUL_BITS=1: MUL a=7, b=0xFFFFFFFD (−3) → result 0xFFFFFFEB, out_valid exactly 33 cycles after accept; repeat with MUL_BITS=4 → same result at 9 cycles.
2. High-half multiplies:
   - MULH 0x80000000×0x80000000 → 0x40000000.
   - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
3. Divides:
   - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
   - DIVU 100/7 → 14; REMU → 2; each with out_valid 33 cycles after accept.
4. Special cases, each with out_valid 1 cycle after accept and busy high for exactly 1 cycle when out_ready=1:
   - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE → result, out_tag (e.g. 5'd13) and out_valid stay stable, in_ready=0. Raise out_ready → IDLE next edge; a new in_valid that same cycle is not accepted until in_ready=1.
6. Flush and reset:
   - kill on the 10th CALC cycle of a DIV → out_valid never rises, in_ready=1 next cycle.
   - kill and in_valid in the same IDLE cycle → no accept.
   - rst pulse between edges mid-MUL → out_valid/busy go to 0 and in_ready to 1 immediately.
